// File: rtl/fp16_mul_pipe.sv
// Two-stage FP16 multiplier with valid/ready handshake.
// S1 forms sign, exponent sum, mantissa product and special flags; S2 normalises, rounds and packs.
module fp16_mul_pipe #(
  parameter bit RNE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product
);

  logic               advance;

  logic               v1_q, v1_d;
  logic               sign1_q, sign1_d;
  logic signed [6:0]  exp1_q, exp1_d;
  logic [21:0]        mant1_q, mant1_d;
  logic               nan1_q, nan1_d;
  logic               inf1_q, inf1_d;
  logic               zero1_q, zero1_d;

  logic               v2_q, v2_d;
  logic [15:0]        prod_q, prod_d;

  logic [4:0]         ea, eb;
  logic [9:0]         fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [10:0]        ma, mb;

  logic [9:0]         norm_m;
  logic               guard, sticky, rnd;
  logic [10:0]        rsum;
  logic signed [6:0]  exp_n, exp_r;
  logic [15:0]        pack;

  assign advance   = !v2_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = v2_q;
  assign product   = prod_q;

  // Stage 1: subnormal operands count as zero and contribute no mantissa.
  always_comb begin
    ea     = a[14:10];
    eb     = b[14:10];
    fa     = a[9:0];
    fb     = b[9:0];
    a_zero = (ea == 5'd0);
    b_zero = (eb == 5'd0);
    a_inf  = (ea == 5'h1F) && (fa == 10'd0);
    b_inf  = (eb == 5'h1F) && (fb == 10'd0);
    a_nan  = (ea == 5'h1F) && (fa != 10'd0);
    b_nan  = (eb == 5'h1F) && (fb != 10'd0);
    ma     = a_zero ? '0 : {1'b1, fa};
    mb     = b_zero ? '0 : {1'b1, fb};

    v1_d    = v1_q;
    sign1_d = sign1_q;
    exp1_d  = exp1_q;
    mant1_d = mant1_q;
    nan1_d  = nan1_q;
    inf1_d  = inf1_q;
    zero1_d = zero1_q;
    if (advance) begin
      v1_d    = in_valid;
      sign1_d = a[15] ^ b[15];
      exp1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15;
      mant1_d = ma * mb;
      nan1_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
      inf1_d  = a_inf || b_inf;
      zero1_d = a_zero || b_zero;
    end
  end

  // Stage 2: on a 2.x product the bit shifted out still feeds sticky.
  always_comb begin
    norm_m = mant1_q[21] ? mant1_q[20:11] : mant1_q[19:10];
    guard  = mant1_q[21] ? mant1_q[10]    : mant1_q[9];
    sticky = mant1_q[21] ? (|mant1_q[9:0]) : (|mant1_q[8:0]);
    exp_n  = exp1_q + $signed({6'b0, mant1_q[21]});
    rnd    = RNE && guard && (sticky || norm_m[0]);
    rsum   = {1'b0, norm_m} + {10'b0, rnd};
    exp_r  = exp_n + $signed({6'b0, rsum[10]});

    if (nan1_q)                pack = 16'h7E00;
    else if (inf1_q)           pack = {sign1_q, 5'h1F, 10'h000};
    else if (zero1_q)          pack = {sign1_q, 15'h0000};
    else if (exp_r >= 7'sd31)  pack = {sign1_q, 5'h1F, 10'h000};
    else if (exp_r <= 7'sd0)   pack = {sign1_q, 15'h0000};
    else                       pack = {sign1_q, exp_r[4:0], rsum[9:0]};

    v2_d   = v2_q;
    prod_d = prod_q;
    if (advance) begin
      v2_d   = v1_q;
      prod_d = pack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      exp1_q  <= '0;
      mant1_q <= '0;
      nan1_q  <= 1'b0;
      inf1_q  <= 1'b0;
      zero1_q <= 1'b0;
      v2_q    <= 1'b0;
      prod_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      sign1_q <= sign1_d;
      exp1_q  <= exp1_d;
      mant1_q <= mant1_d;
      nan1_q  <= nan1_d;
      inf1_q  <= inf1_d;
      zero1_q <= zero1_d;
      v2_q    <= v2_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_fp16_mul_pipe.sv
// Scoreboard bench for fp16_mul_pipe: one RNE=1 and one RNE=0 instance share stimulus.
module tb_fp16_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, in_ready0, out_valid0;
  logic [15:0] product, product0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;

  typedef struct {
    logic [15:0] a, b, e1, e0;
    int          due;
    bit          lat;
  } item_t;

  item_t sb[$];

  typedef struct {
    logic [15:0] a, b, e1, e0;
  } vec_t;

  vec_t vecs[15] = '{
    '{16'h3E00, 16'h3E00, 16'h4080, 16'h4080},
    '{16'hC000, 16'h4200, 16'hC600, 16'hC600},
    '{16'h3800, 16'h3800, 16'h3400, 16'h3400},
    '{16'h7BFF, 16'h7BFF, 16'h7C00, 16'h7C00},
    '{16'h7C00, 16'h0000, 16'h7E00, 16'h7E00},
    '{16'h7E00, 16'h3C00, 16'h7E00, 16'h7E00},
    '{16'h0001, 16'h3C00, 16'h0000, 16'h0000},
    '{16'h3C01, 16'h3C01, 16'h3C02, 16'h3C02},
    '{16'h3E01, 16'h3E01, 16'h4082, 16'h4081},
    '{16'h0400, 16'h0400, 16'h0000, 16'h0000},
    '{16'h8400, 16'h0400, 16'h8000, 16'h8000},
    '{16'hFC00, 16'h3C00, 16'hFC00, 16'hFC00},
    '{16'h0000, 16'h8000, 16'h8000, 16'h8000},
    '{16'h7C00, 16'hFC00, 16'hFC00, 16'hFC00},
    '{16'h0000, 16'h7C00, 16'h7E00, 16'h7E00}
  };

  fp16_mul_pipe #(.RNE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  fp16_mul_pipe #(.RNE(1'b0)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready), .product(product0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input vec_t v, input bit lat);
    item_t it;
    it.a = v.a; it.b = v.b; it.e1 = v.e1; it.e0 = v.e0;
    it.due = cyc + 2;
    it.lat = lat;
    sb.push_back(it);
    n_in++;
  endtask

  // Called at a falling edge: presents v and pushes it once accepted.
  task automatic send(input vec_t v, input bit lat);
    int wait_cnt;
    a = v.a; b = v.b; in_valid = 1'b1;
    #1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(negedge clk); #1;
      wait_cnt++;
    end
    if (!in_ready) chk("send_timeout", 16'(in_ready), 16'h1);
    else push(v, lat);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: every completed output transfer pops one expectation.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("unexpected_output", product, 16'hxxxx);
        end else begin
          it = sb.pop_front();
          chk($sformatf("rne1 %h*%h", it.a, it.b), product, it.e1);
          chk($sformatf("rne0 %h*%h", it.a, it.b), product0, it.e0);
          chk("valid_pair", 16'(out_valid0), 16'h1);
          if (it.lat) chk_int($sformatf("latency %h*%h", it.a, it.b), cyc, it.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    vec_t p1, p2, p3;
    int guard_cnt;

    // Reset state
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_product", product, 16'h0000);
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(vecs[0], 1'b1);
    repeat (3) @(negedge clk);

    // Directed vectors, one at a time, latency checked
    for (int i = 1; i < 15; i++) begin
      send(vecs[i], 1'b1);
      repeat (3) @(negedge clk);
    end

    // Back-to-back stream with a 3-cycle downstream stall
    p1 = vecs[0]; p2 = vecs[1]; p3 = vecs[2];
    out_ready = 1'b1;
    a = p1.a; b = p1.b; in_valid = 1'b1;
    #1; chk("stream_in_ready1", 16'(in_ready), 16'h1); push(p1, 1'b0);
    @(negedge clk);
    a = p2.a; b = p2.b;
    #1; chk("stream_in_ready2", 16'(in_ready), 16'h1); push(p2, 1'b0);
    @(negedge clk);
    a = p3.a; b = p3.b;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("stall_out_valid", 16'(out_valid), 16'h1);
      chk("stall_in_ready", 16'(in_ready), 16'h0);
      chk("stall_product", product, p1.e1);
      chk("stall_product0", product0, p1.e0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1; chk("unstall_in_ready", 16'(in_ready), 16'h1); push(p3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk_int("stream_drained", sb.size(), 0);

    // Reset with two pairs in flight
    out_ready = 1'b0;
    a = vecs[3].a; b = vecs[3].b; in_valid = 1'b1;
    @(negedge clk);
    a = vecs[4].a; b = vecs[4].b;
    @(negedge clk);
    in_valid = 1'b0;
    #1; chk("inflight_valid", 16'(out_valid), 16'h1);
    #2; rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 16'(out_valid), 16'h0);
    chk("async_rst_product", product, 16'h0000);
    chk("async_rst_in_ready", 16'(in_ready), 16'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(vecs[1], 1'b1);
    #1; chk("post_rst_no_stale", 16'(out_valid), 16'h0);
    repeat (4) @(negedge clk);

    guard_cnt = 0;
    while (sb.size() != 0 && guard_cnt < 20) begin
      @(negedge clk);
      guard_cnt++;
    end
    chk_int("scoreboard_empty", sb.size(), 0);
    chk_int("in_out_count", n_out, n_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
